// File: rtl/led_shift_engine.sv
// -----------------------------------------------------------------------------
// led_shift_engine
//
// Purpose:
//   Drives an LED bank with a pattern selected by push-buttons. The pattern
//   advances one step per rising edge of the upstream rate tick. A tick held
//   high yields a single step. Buttons are synchronised, then edge-detected.
//
// Ports:
//   clock    in   system clock
//   i_reset  in   synchronous, active-high reset
//   i_valid  in   step tick; may be a 1-cycle pulse or held high
//   i_btn    in   async buttons: bit0=ROT_L, bit1=ROT_R, bit2=PING, bit3=FLASH
//   o_led    out  LED pattern (registered)
//   o_mode   out  current mode: 0=ROT_L, 1=ROT_R, 2=PING, 3=FLASH (registered)
//   o_dir    out  ping-pong direction, 0=toward MSB, 1=toward LSB (registered)
// -----------------------------------------------------------------------------
module led_shift_engine #(
  parameter int NB_LEDS = 4,
  parameter int NB_BTN  = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [1:0]         o_mode,
  output logic               o_dir
);

  typedef enum logic [1:0] {
    MODE_ROT_L = 2'd0,
    MODE_ROT_R = 2'd1,
    MODE_PING  = 2'd2,
    MODE_FLASH = 2'd3
  } mode_t;

  localparam logic [NB_LEDS-1:0] LED_LSB  = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_MSB  = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] LED_ALL  = {NB_LEDS{1'b1}};

  // Circular moves: pure bit permutations, population count preserved.
  function automatic logic [NB_LEDS-1:0] rot_left(input logic [NB_LEDS-1:0] v);
    return {v[NB_LEDS-2:0], v[NB_LEDS-1]};
  endfunction

  function automatic logic [NB_LEDS-1:0] rot_right(input logic [NB_LEDS-1:0] v);
    return {v[0], v[NB_LEDS-1:1]};
  endfunction

  logic [NB_BTN-1:0]  sync1_q, sync1_d;
  logic [NB_BTN-1:0]  sync2_q, sync2_d;
  logic [NB_BTN-1:0]  hist_q,  hist_d;
  logic               valid_q, valid_d;
  logic [NB_LEDS-1:0] led_q,   led_d;
  mode_t              mode_q,  mode_d;
  logic               dir_q,   dir_d;

  logic [NB_BTN-1:0]  press;
  logic               step;
  logic [NB_LEDS-1:0] ping_next;

  // ---- edge detection: button presses and tick rising edge ----
  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    valid_d = i_valid;
    press   = sync2_q & ~hist_q;
    step    = i_valid & ~valid_q;
  end

  // ---- next-state: mode change beats step; a colliding step is dropped ----
  always_comb begin
    led_d     = led_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    ping_next = dir_q ? (led_q >> 1) : (led_q << 1);

    if (press[0]) begin
      mode_d = MODE_ROT_L;
      led_d  = LED_LSB;
      dir_d  = 1'b0;
    end else if (press[1]) begin
      mode_d = MODE_ROT_R;
      led_d  = LED_MSB;
      dir_d  = 1'b0;
    end else if (press[2]) begin
      mode_d = MODE_PING;
      led_d  = LED_LSB;
      dir_d  = 1'b0;
    end else if (press[3]) begin
      mode_d = MODE_FLASH;
      led_d  = LED_ALL;
      dir_d  = 1'b0;
    end else if (step) begin
      case (mode_q)
        MODE_ROT_L: led_d = rot_left(led_q);
        MODE_ROT_R: led_d = rot_right(led_q);
        MODE_PING: begin
          led_d = ping_next;
          // Turn around on the same edge the end is reached so the next
          // step leaves the end immediately (no dwell).
          if (!dir_q && ping_next[NB_LEDS-1]) dir_d = 1'b1;
          if ( dir_q && ping_next[0])         dir_d = 1'b0;
        end
        MODE_FLASH: led_d = ~led_q;
      endcase
    end
  end

  // ---- state registers ----
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      valid_q <= 1'b0;
      led_q   <= LED_LSB;
      mode_q  <= MODE_ROT_L;
      dir_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      valid_q <= valid_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_dir  = dir_q;

endmodule

// File: tb/tb_led_shift_engine.sv
module tb_led_shift_engine;

  localparam int N = 4;

  logic         clock;
  logic         i_reset;
  logic         i_valid;
  logic [3:0]   i_btn;
  logic [N-1:0] o_led;
  logic [1:0]   o_mode;
  logic         o_dir;

  led_shift_engine #(.NB_LEDS(N), .NB_BTN(4)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_mode  (o_mode),
    .o_dir   (o_dir)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: mode number, LED value as an integer, ping position.
  int m_mode;
  int m_led;
  int m_dir;
  int m_pos;

  function automatic int lowest_bit(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_led = 1; m_dir = 0; m_pos = 0;
  endtask

  task automatic model_enter(input int md);
    m_mode = md;
    m_dir  = 0;
    m_pos  = 0;
    case (md)
      0: m_led = 1;
      1: m_led = 1 << (N-1);
      2: m_led = 1;
      default: m_led = (1 << N) - 1;
    endcase
  endtask

  task automatic model_step();
    case (m_mode)
      0: m_led = (m_led * 2) % (1 << N) + m_led / (1 << (N-1));
      1: m_led = m_led / 2 + (m_led % 2) * (1 << (N-1));
      2: begin
        if (m_dir == 0) begin
          m_pos = m_pos + 1;
          if (m_pos == N-1) m_dir = 1;
        end else begin
          m_pos = m_pos - 1;
          if (m_pos == 0) m_dir = 0;
        end
        m_led = 1 << m_pos;
      end
      default: m_led = ((1 << N) - 1) - m_led;
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag);
    logic [N-1:0] e_led;
    logic [1:0]   e_mode;
    logic         e_dir;
    e_led  = m_led[N-1:0];
    e_mode = m_mode[1:0];
    e_dir  = m_dir[0];
    n_cmp++;
    assert (o_led === e_led) else begin
      n_mis++;
      $error("FAIL %s led observed=%b expected=%b", tag, o_led, e_led);
    end
    n_cmp++;
    assert (o_mode === e_mode) else begin
      n_mis++;
      $error("FAIL %s mode observed=%0d expected=%0d", tag, o_mode, e_mode);
    end
    n_cmp++;
    assert (o_dir === e_dir) else begin
      n_mis++;
      $error("FAIL %s dir observed=%b expected=%b", tag, o_dir, e_dir);
    end
  endtask

  // Tick high for 'hold' cycles (one step total), then low for 'gap' cycles.
  task automatic pulse(input int hold, input int gap, input string tag);
    i_valid = 1'b1;
    cyc(1);
    model_step();
    check({tag, "_step"});
    if (hold > 1) begin
      cyc(hold - 1);
      check({tag, "_hold"});
    end
    i_valid = 1'b0;
    cyc(gap);
    check({tag, "_gap"});
  endtask

  // Mode must not change after 2 edges, must change on the 3rd.
  task automatic press(input logic [3:0] b, input string tag);
    i_btn = b;
    cyc(2);
    check({tag, "_early"});
    cyc(1);
    model_enter(lowest_bit(b));
    check({tag, "_hit"});
    i_btn = 4'b0;
    cyc(3);
    check({tag, "_rel"});
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_btn   = 4'b0;
    model_reset();
    cyc(2);
    check("reset");
    i_reset = 1'b0;
    cyc(2);
    check("idle");

    // Rotate-left with spaced single-cycle pulses, including wrap.
    for (int i = 0; i < 5; i++) pulse(1, 10, "rotl");

    // Held tick: one step; low one cycle; high again: one more step.
    model_reset();
    i_reset = 1'b1; cyc(1); i_reset = 1'b0;
    check("reset2");
    pulse(20, 1, "held_a");
    pulse(3, 2, "held_b");

    // Ping-pong through both turnarounds.
    press(4'b0100, "ping_sel");
    for (int i = 0; i < 7; i++) pulse(1, 2, "ping");

    // Flash, then held button across steps must not retrigger.
    press(4'b1000, "flash_sel");
    for (int i = 0; i < 3; i++) pulse(1, 2, "flash");
    i_btn = 4'b0010;
    cyc(3);
    model_enter(1);
    check("rotr_sel");
    pulse(1, 2, "rotr_heldbtn");
    pulse(1, 2, "rotr_heldbtn");
    i_btn = 4'b0;
    cyc(3);
    check("rotr_rel");

    // Reselecting the active mode reloads its entry pattern.
    press(4'b0010, "rotr_reload");

    // Button press and step in the same cycle: press wins, step dropped.
    pulse(1, 2, "pre_coll");
    i_btn = 4'b0110;
    cyc(2);
    i_valid = 1'b1;
    cyc(1);
    model_enter(1);
    check("collide");
    i_btn = 4'b0;
    cyc(3);
    check("collide_held");
    i_valid = 1'b0;
    cyc(2);
    check("collide_end");

    // Reset mid-ping together with a tick; tick still high after reset steps once.
    press(4'b0100, "ping2_sel");
    for (int i = 0; i < 4; i++) pulse(1, 2, "ping2");
    check("ping2_pre");
    i_reset = 1'b1;
    i_valid = 1'b1;
    cyc(1);
    model_reset();
    check("mid_reset");
    i_reset = 1'b0;
    cyc(1);
    model_step();
    check("post_reset_step");
    cyc(3);
    check("post_reset_hold");
    i_valid = 1'b0;
    cyc(2);

    // Randomized mix of presses and ticks.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        press(4'($urandom_range(1, 15)), "rnd_press");
      else
        pulse($urandom_range(1, 4), $urandom_range(1, 6), "rnd_pulse");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
